// File: rtl/brcmp_pkg.sv
// -----------------------------------------------------------------------------
// brcmp_pkg
// Shared definitions for the sequential branch comparator:
//   - funct3 encodings of the six RISC-V conditional branches
//   - FSM state type of branch_compare_seq
//   - brcmp_map(): folds {funct3, eq, lt} into {taken, illegal}
// -----------------------------------------------------------------------------
package brcmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } brcmp_state_e;

  // Returns {taken, illegal}. The two reserved encodings (010, 011) never
  // take the branch.
  function automatic logic [1:0] brcmp_map(input logic [2:0] f3,
                                           input logic       eq,
                                           input logic       lt);
    logic taken;
    logic illegal;
    taken   = 1'b0;
    illegal = 1'b0;
    case (f3)
      F3_BEQ:           taken = eq;
      F3_BNE:           taken = !eq;
      F3_BLT, F3_BLTU:  taken = lt;
      F3_BGE, F3_BGEU:  taken = !lt;
      default:          illegal = 1'b1;
    endcase
    return {taken, illegal};
  endfunction

endpackage

// File: rtl/brcmp_slice.sv
// -----------------------------------------------------------------------------
// brcmp_slice
// Combinational unsigned compare of one CHUNK-wide operand slice.
// Ports:
//   a, b      in   CHUNK  slice of operand A / B
//   slice_eq  out  1      a == b
//   slice_lt  out  1      a <  b (unsigned)
// -----------------------------------------------------------------------------
module brcmp_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             slice_eq,
  output logic             slice_lt
);

  assign slice_eq = (a == b);
  assign slice_lt = (a < b);

endmodule

// File: rtl/branch_compare_seq.sv
// -----------------------------------------------------------------------------
// branch_compare_seq
// Multi-cycle RV32 branch comparator. Operands are compared CHUNK bits per
// cycle starting at the most significant slice. Signed compares are turned
// into unsigned ones by flipping the sign bit of both operands on capture.
//
// Build option:
//   BRCMP_EARLY_EXIT_EN  defined   -> stop at the first differing slice
//                        undefined -> always walk all slices (fixed latency
//                                     NSLICE+1), first difference remembered
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   flush                synchronous abort back to IDLE, drops pending result
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   rs1, rs2 [WIDTH]     operands
//   funct3 [3]           branch function
//   out_valid/out_ready  result handshake
//   taken, eq, lt        registered branch result flags
//   illegal              funct3 is a reserved encoding
// -----------------------------------------------------------------------------
module branch_compare_seq
  import brcmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             eq,
  output logic             lt,
  output logic             illegal
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  brcmp_state_e     state_q, state_d;
  logic [IDX_W-1:0] slice_idx_q, slice_idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       f3_q, f3_d;
  logic             taken_q, taken_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             illegal_q, illegal_d;

`ifndef BRCMP_EARLY_EXIT_EN
  // Full-walk build: remember the first (most significant) differing slice.
  logic found_q, found_d;
  logic found_lt_q, found_lt_d;
`endif

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic             slice_eq;
  logic             slice_lt;
  logic             decided;
  logic             res_eq;
  logic             res_lt;
  int               base;

  // Slice mux feeding the single comparator
  always_comb begin
    base    = int'(slice_idx_q) * CHUNK;
    a_slice = a_q[base +: CHUNK];
    b_slice = b_q[base +: CHUNK];
  end

  brcmp_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a        (a_slice),
    .b        (b_slice),
    .slice_eq (slice_eq),
    .slice_lt (slice_lt)
  );

  // Per-cycle decision and the result it would produce
  always_comb begin
`ifdef BRCMP_EARLY_EXIT_EN
    decided = !slice_eq || (slice_idx_q == '0);
    res_eq  = slice_eq;
    res_lt  = slice_lt;
`else
    decided = (slice_idx_q == '0);
    res_eq  = !found_q && slice_eq;
    res_lt  = found_q ? found_lt_q : slice_lt;
`endif
  end

  // Next-state and register updates
  always_comb begin
    state_d     = state_q;
    slice_idx_d = slice_idx_q;
    a_d         = a_q;
    b_d         = b_q;
    f3_d        = f3_q;
    taken_d     = taken_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    illegal_d   = illegal_q;
`ifndef BRCMP_EARLY_EXIT_EN
    found_d     = found_q;
    found_lt_d  = found_lt_q;
`endif

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d     = ST_BUSY;
            // Sign-bit flip makes unsigned slice order equal signed order
            a_d         = funct3[1] ? rs1 : (rs1 ^ SIGN_MASK);
            b_d         = funct3[1] ? rs2 : (rs2 ^ SIGN_MASK);
            f3_d        = funct3;
            slice_idx_d = LAST_IDX;
`ifndef BRCMP_EARLY_EXIT_EN
            found_d     = 1'b0;
            found_lt_d  = 1'b0;
`endif
          end
        end
        ST_BUSY: begin
`ifndef BRCMP_EARLY_EXIT_EN
          if (!found_q && !slice_eq) begin
            found_d    = 1'b1;
            found_lt_d = slice_lt;
          end
`endif
          if (decided) begin
            state_d              = ST_DONE;
            eq_d                 = res_eq;
            lt_d                 = res_lt;
            {taken_d, illegal_d} = brcmp_map(f3_q, res_eq, res_lt);
          end else begin
            slice_idx_d = slice_idx_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      slice_idx_q <= '0;
      taken_q     <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      illegal_q   <= 1'b0;
`ifndef BRCMP_EARLY_EXIT_EN
      found_q     <= 1'b0;
      found_lt_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      slice_idx_q <= slice_idx_d;
      taken_q     <= taken_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
      illegal_q   <= illegal_d;
`ifndef BRCMP_EARLY_EXIT_EN
      found_q     <= found_d;
      found_lt_q  <= found_lt_d;
`endif
    end
  end

  // Operand registers: only meaningful after an accept, so no reset
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    f3_q <= f3_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign taken     = taken_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign illegal   = illegal_q;

endmodule
